// File: rtl/sccb_slave_if.sv
// Register-side port of the SCCB responder: pointer, write data/strobe,
// read strobe/data and the bus-busy flag.
`timescale 1ns/1ps
interface sccb_slave_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  modport slave (
    output reg_addr, reg_wdata, reg_we, reg_re, busy,
    input  reg_rdata
  );

  modport master (
    input  reg_addr, reg_wdata, reg_we, reg_re, busy,
    output reg_rdata
  );
endinterface

// File: rtl/sccb_slave.sv
// SCCB/I2C target: oversampled START/STOP detection, 7-bit ID match,
// 3-phase writes and 2-phase reads against a synchronous register port.
`timescale 1ns/1ps
module sccb_slave #(
  parameter logic [6:0] DEV_ID = 7'h21
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sioc_i,
  inout  wire         siod_io,
  sccb_slave_if.slave reg_if
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_REG, S_REG_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sioc_sync_q, sioc_sync_d;
  logic [2:0]  siod_sync_q, siod_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        busy_q, busy_d;
  logic        sda_low_q, sda_low_d;
  logic        rd_mode_q, rd_mode_d;
  logic        phase_q, phase_d;
  logic        load_q, load_d;

  logic        scl_s, scl_prev_s, sda_s, sda_prev_s;
  logic        rise_s, fall_s, start_s, stop_s;
  logic [7:0]  byte_in_s;

  assign scl_s      = sioc_sync_q[1];
  assign scl_prev_s = sioc_sync_q[2];
  assign sda_s      = siod_sync_q[1];
  assign sda_prev_s = siod_sync_q[2];
  assign rise_s     = scl_s & ~scl_prev_s;
  assign fall_s     = ~scl_s & scl_prev_s;
  assign start_s    = scl_s & scl_prev_s & sda_prev_s & ~sda_s;
  assign stop_s     = scl_s & scl_prev_s & ~sda_prev_s & sda_s;
  assign byte_in_s  = {shift_q[6:0], sda_s};

  // Open-drain: only ever pull low; reset releases the line immediately.
  assign siod_io = (sda_low_q && !rst_i) ? 1'b0 : 1'bz;

  assign reg_if.reg_addr  = addr_q;
  assign reg_if.reg_wdata = wdata_q;
  assign reg_if.reg_we    = we_q;
  assign reg_if.reg_re    = re_q;
  assign reg_if.busy      = busy_q;

  // Next-state and output computation for the bus protocol.
  always_comb begin
    state_d     = state_q;
    sioc_sync_d = {sioc_sync_q[1:0], sioc_i};
    siod_sync_d = {siod_sync_q[1:0], siod_io};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    busy_d      = busy_q;
    sda_low_d   = sda_low_q;
    rd_mode_d   = rd_mode_q;
    phase_d     = phase_q;
    load_d      = load_q;

    if (start_s) begin
      state_d   = S_DEV;
      bit_cnt_d = 3'd0;
      sda_low_d = 1'b0;
      phase_d   = 1'b0;
      load_d    = 1'b0;
    end else if (stop_s) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
      phase_d   = 1'b0;
      load_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT_STOP: begin
          busy_d    = 1'b0;
          sda_low_d = 1'b0;
        end
        S_DEV, S_REG, S_WR: begin
          if (rise_s) begin
            shift_d   = byte_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_DEV: begin
                  if (byte_in_s[7:1] == DEV_ID) begin
                    state_d   = S_DEV_ACK;
                    busy_d    = 1'b1;
                    rd_mode_d = byte_in_s[0];
                  end else begin
                    state_d   = S_WAIT_STOP;
                  end
                end
                S_REG: begin
                  addr_d  = byte_in_s;
                  state_d = S_REG_ACK;
                end
                default: begin
                  wdata_d = byte_in_s;
                  we_d    = 1'b1;
                  state_d = S_WR_ACK;
                end
              endcase
            end else begin
              state_d = state_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // ACK is held low for exactly one SIOC low-high-low window.
        S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
          if (fall_s && !phase_q) begin
            sda_low_d = 1'b1;
            phase_d   = 1'b1;
          end else if (fall_s) begin
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
            case (state_q)
              S_DEV_ACK: begin
                if (rd_mode_q) begin
                  state_d = S_RD;
                  re_d    = 1'b1;
                  load_d  = 1'b1;
                end else begin
                  state_d = S_REG;
                end
              end
              S_REG_ACK: state_d = S_WR;
              default: begin
                addr_d  = addr_q + 8'd1;
                state_d = S_WR;
              end
            endcase
          end else begin
            phase_d = phase_q;
          end
        end
        S_RD: begin
          if (load_q) begin
            shift_d   = reg_if.reg_rdata;
            sda_low_d = ~reg_if.reg_rdata[7];
            load_d    = 1'b0;
          end else if (rise_s) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            phase_d   = (bit_cnt_q == 3'd7);
          end else if (fall_s && phase_q) begin
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
            state_d   = S_RD_ACK;
          end else if (fall_s) begin
            sda_low_d = ~shift_q[7];
          end else begin
            sda_low_d = sda_low_q;
          end
        end
        // Pointer advances on master ACK so it is settled before the next read strobe.
        S_RD_ACK: begin
          if (rise_s && !sda_s) begin
            addr_d  = addr_q + 8'd1;
            phase_d = 1'b1;
          end else if (rise_s) begin
            state_d = S_WAIT_STOP;
          end else if (fall_s && phase_q) begin
            phase_d = 1'b0;
            re_d    = 1'b1;
            load_d  = 1'b1;
            state_d = S_RD;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sioc_sync_q <= 3'b111;
      siod_sync_q <= 3'b111;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_low_q   <= 1'b0;
      rd_mode_q   <= 1'b0;
      phase_q     <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
      sda_low_q   <= sda_low_d;
      rd_mode_q   <= rd_mode_d;
      phase_q     <= phase_d;
      load_q      <= load_d;
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master on an open-drain
// SIOD line, a small register-read model and strobe logging.
`timescale 1ns/1ps
module tb_sccb_slave;

  localparam time Q = 100ns;

  logic clk = 1'b0;
  logic rst_i;
  logic sioc;
  logic m_low;
  wire  siod_w;

  sccb_slave_if bus ();

  assign siod_w = m_low ? 1'b0 : 1'bz;
  pullup (siod_w);

  // Register read model: fixed value at 0x0A, otherwise address xor 0x3C.
  assign bus.reg_rdata = (bus.reg_addr == 8'h0A) ? 8'hA5 : (bus.reg_addr ^ 8'h3C);

  sccb_slave #(.DEV_ID(7'h21)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .sioc_i  (sioc),
    .siod_io (siod_w),
    .reg_if  (bus)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int we_cnt = 0, re_cnt = 0, low_cnt = 0, dbl_cnt = 0;
  logic [7:0] we_addr_log [32];
  logic [7:0] we_data_log [32];
  logic [7:0] re_addr_log [32];
  logic       we_prev = 1'b0, re_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_addr_log[we_cnt[4:0]] = bus.reg_addr;
      we_data_log[we_cnt[4:0]] = bus.reg_wdata;
      we_cnt++;
    end
    if (bus.reg_re) begin
      re_addr_log[re_cnt[4:0]] = bus.reg_addr;
      re_cnt++;
    end
    if ((bus.reg_we && we_prev) || (bus.reg_re && re_prev)) dbl_cnt++;
    if (!m_low && siod_w === 1'b0) low_cnt++;
    we_prev = bus.reg_we;
    re_prev = bus.reg_re;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_start();
    m_low = 1'b0; #(Q);
    sioc  = 1'b1; #(Q);
    m_low = 1'b1; #(Q);
    sioc  = 1'b0; #(Q);
  endtask

  task automatic m_stop();
    m_low = 1'b1; #(Q);
    sioc  = 1'b1; #(Q);
    m_low = 1'b0; #(Q);
  endtask

  task automatic m_bit(input logic b);
    m_low = ~b; #(Q);
    sioc  = 1'b1; #(2*Q);
    sioc  = 1'b0; #(Q);
  endtask

  task automatic m_write(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(data[i]);
    m_low = 1'b0; #(Q);
    sioc  = 1'b1; #(Q);
    ack   = (siod_w === 1'b0);
    #(Q);
    sioc  = 1'b0; #(Q);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] data);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(Q);
      sioc = 1'b1; #(Q);
      data[i] = (siod_w === 1'b1);
      #(Q);
      sioc = 1'b0;
    end
    #(Q);
    m_low = ~nack; #(Q);
    sioc  = 1'b1;  #(2*Q);
    sioc  = 1'b0;  #(Q);
    m_low = 1'b0;
  endtask

  logic       ack;
  logic [7:0] rd;
  int         we0, re0, low0;

  initial begin
    rst_i = 1'b1;
    sioc  = 1'b1;
    m_low = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_i = 1'b0;
    @(negedge clk);
    check("rst_addr",  {24'd0, bus.reg_addr},  32'h00);
    check("rst_wdata", {24'd0, bus.reg_wdata}, 32'h00);
    check("rst_we",    {31'd0, bus.reg_we},    32'h0);
    check("rst_re",    {31'd0, bus.reg_re},    32'h0);
    check("rst_busy",  {31'd0, bus.busy},      32'h0);
    check("rst_siod",  {31'd0, siod_w},        32'h1);
    #(Q);

    // Single write
    we0 = we_cnt;
    m_start();
    m_write(8'h42, ack); check("wr_ack_id",   {31'd0, ack}, 32'h1);
    m_write(8'h12, ack); check("wr_ack_reg",  {31'd0, ack}, 32'h1);
    m_write(8'h80, ack); check("wr_ack_data", {31'd0, ack}, 32'h1);
    check("wr_busy_hi", {31'd0, bus.busy}, 32'h1);
    check("wr_we_cnt",  we_cnt - we0, 1);
    check("wr_addr",    {24'd0, we_addr_log[we0[4:0]]}, 32'h12);
    check("wr_data",    {24'd0, we_data_log[we0[4:0]]}, 32'h80);
    m_stop();
    #(Q);
    check("wr_busy_lo", {31'd0, bus.busy}, 32'h0);

    // Single read with NACK
    m_start(); m_write(8'h42, ack); m_write(8'h0A, ack); m_stop();
    re0 = re_cnt;
    m_start();
    m_write(8'h43, ack); check("rd_ack_id", {31'd0, ack}, 32'h1);
    m_read(1'b1, rd);
    check("rd_data",   {24'd0, rd}, 32'hA5);
    check("rd_re_cnt", re_cnt - re0, 1);
    check("rd_addr",   {24'd0, re_addr_log[re0[4:0]]}, 32'h0A);
    m_stop();

    // Write burst across the 0xFF wrap
    we0 = we_cnt;
    m_start();
    m_write(8'h42, ack); m_write(8'hFE, ack);
    m_write(8'h11, ack); m_write(8'h22, ack); m_write(8'h33, ack);
    check("bw_ack_last", {31'd0, ack}, 32'h1);
    m_stop();
    check("bw_we_cnt", we_cnt - we0, 3);
    check("bw_addr0", {24'd0, we_addr_log[we0[4:0]]},        32'hFE);
    check("bw_addr1", {24'd0, we_addr_log[(we0 + 1) % 32]}, 32'hFF);
    check("bw_addr2", {24'd0, we_addr_log[(we0 + 2) % 32]}, 32'h00);
    check("bw_data2", {24'd0, we_data_log[(we0 + 2) % 32]}, 32'h33);

    // Read burst: ACK then NACK
    m_start(); m_write(8'h42, ack); m_write(8'h40, ack); m_stop();
    re0 = re_cnt;
    m_start(); m_write(8'h43, ack);
    m_read(1'b0, rd); check("br_data0", {24'd0, rd}, 32'h7C);
    m_read(1'b1, rd); check("br_data1", {24'd0, rd}, 32'h7D);
    m_stop();
    check("br_re_cnt", re_cnt - re0, 2);
    check("br_addr0", {24'd0, re_addr_log[re0[4:0]]},        32'h40);
    check("br_addr1", {24'd0, re_addr_log[(re0 + 1) % 32]}, 32'h41);

    // Wrong device ID
    we0 = we_cnt; re0 = re_cnt; low0 = low_cnt;
    m_start();
    m_write(8'h44, ack); check("wid_nack", {31'd0, ack}, 32'h0);
    m_write(8'h12, ack); check("wid_nack2", {31'd0, ack}, 32'h0);
    check("wid_busy", {31'd0, bus.busy}, 32'h0);
    m_stop();
    check("wid_low",    low_cnt - low0, 0);
    check("wid_strobe", (we_cnt - we0) + (re_cnt - re0), 0);
    m_start();
    m_write(8'h42, ack); check("wid_recover", {31'd0, ack}, 32'h1);
    check("wid_busy2", {31'd0, bus.busy}, 32'h1);
    m_stop();

    // Repeated START in the middle of a data byte
    we0 = we_cnt; re0 = re_cnt;
    m_start(); m_write(8'h42, ack); m_write(8'h20, ack);
    m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b0);
    m_start();
    m_write(8'h43, ack); check("rs_ack", {31'd0, ack}, 32'h1);
    m_read(1'b1, rd);    check("rs_data", {24'd0, rd}, 32'h1C);
    m_stop();
    check("rs_we_cnt", we_cnt - we0, 0);
    check("rs_re_cnt", re_cnt - re0, 1);

    // Reset while the block is driving a read zero
    m_start(); m_write(8'h42, ack); m_write(8'h30, ack); m_stop();
    m_start(); m_write(8'h43, ack);
    check("rr_drive0", {31'd0, siod_w}, 32'h0);
    @(negedge clk) rst_i = 1'b1;
    @(negedge clk) rst_i = 1'b0;
    check("rr_siod", {31'd0, siod_w},    32'h1);
    check("rr_addr", {24'd0, bus.reg_addr}, 32'h00);
    check("rr_busy", {31'd0, bus.busy},  32'h0);
    check("rr_strb", {30'd0, bus.reg_we, bus.reg_re}, 32'h0);
    #(Q);
    check("rr_stay_rel", {31'd0, siod_w}, 32'h1);
    sioc = 1'b1; #(Q);

    check("strobe_width", dbl_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
